// File: rtl/l2_dispatch_arbiter.sv
// Picks which L2 input stream the controller FSM services next and holds the
// one-hot grant until the FSM reports completion. Also boosts CPU priority when the CPU is starved.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant outstanding; any eligible stream is granted next edge
// GRANT   | one do_* held high until fsm_done, then re-arbitrate same edge
module l2_dispatch_arbiter #(
  parameter int N_MSHR       = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int MSHR_CNT_W   = 3,
  parameter int STARVE_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rsp_valid_i,
  input  logic                  fwd_valid_i,
  input  logic                  flush_valid_i,
  input  logic                  fence_valid_i,
  input  logic                  cpu_valid_i,
  input  logic                  fwd_stall_i,
  input  logic                  set_conflict_i,
  input  logic                  evict_stall_i,
  input  logic [MSHR_CNT_W-1:0] mshr_cnt_i,
  input  logic                  fsm_done_i,
  output logic                  do_rsp_o,
  output logic                  do_fwd_o,
  output logic                  do_flush_o,
  output logic                  do_fence_o,
  output logic                  do_cpu_req_o,
  output logic                  busy_o,
  output logic                  starve_boost_o
);

  localparam int IDX_RSP   = 0;
  localparam int IDX_FWD   = 1;
  localparam int IDX_FLUSH = 2;
  localparam int IDX_FENCE = 3;
  localparam int IDX_CPU   = 4;
  localparam int N_SRC     = 5;

  localparam logic [MSHR_CNT_W-1:0] MSHR_FULL  = MSHR_CNT_W'(N_MSHR);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N_SRC-1:0]    gnt_q, gnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic [N_SRC-1:0]    elig;
  logic [N_SRC-1:0]    winner;
  logic                any_elig;
  logic                boost;
  logic                grant_load;

  // Flush and fence must wait for every outstanding miss to retire.
  always_comb begin
    elig            = '0;
    elig[IDX_RSP]   = rsp_valid_i;
    elig[IDX_FWD]   = fwd_valid_i & ~fwd_stall_i;
    elig[IDX_FLUSH] = flush_valid_i & (mshr_cnt_i == '0);
    elig[IDX_FENCE] = fence_valid_i & (mshr_cnt_i == '0);
    elig[IDX_CPU]   = cpu_valid_i & ~set_conflict_i & ~evict_stall_i &
                      (mshr_cnt_i < MSHR_FULL);
  end

  assign any_elig = |elig;
  assign boost    = (starve_q == STARVE_MAX) & elig[IDX_CPU];

  // Responses always win so they drain even while the CPU is boosted.
  always_comb begin
    winner = '0;
    if (elig[IDX_RSP]) begin
      winner[IDX_RSP] = 1'b1;
    end else if (boost) begin
      winner[IDX_CPU] = 1'b1;
    end else if (elig[IDX_FWD]) begin
      winner[IDX_FWD] = 1'b1;
    end else if (elig[IDX_FLUSH]) begin
      winner[IDX_FLUSH] = 1'b1;
    end else if (elig[IDX_FENCE]) begin
      winner[IDX_FENCE] = 1'b1;
    end else if (elig[IDX_CPU]) begin
      winner[IDX_CPU] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          gnt_d      = winner;
          grant_load = 1'b1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (fsm_done_i) begin
          if (any_elig) begin
            gnt_d      = winner;
            grant_load = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counts consecutive non-CPU grants while the CPU is waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_load) begin
      if (winner[IDX_CPU]) begin
        starve_d = '0;
      end else if (cpu_valid_i && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
    if (!cpu_valid_i) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      starve_q <= starve_d;
    end
  end

  assign do_rsp_o       = gnt_q[IDX_RSP];
  assign do_fwd_o       = gnt_q[IDX_FWD];
  assign do_flush_o     = gnt_q[IDX_FLUSH];
  assign do_fence_o     = gnt_q[IDX_FENCE];
  assign do_cpu_req_o   = gnt_q[IDX_CPU];
  assign busy_o         = (state_q == ST_GRANT);
  assign starve_boost_o = boost;

endmodule

// File: tb/tb_l2_dispatch_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural arbitration model.
module tb_l2_dispatch_arbiter;

  localparam int N_MSHR = 4;
  localparam int LIMIT  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rsp_valid = 0, fwd_valid = 0, flush_valid = 0, fence_valid = 0, cpu_valid = 0;
  logic       fwd_stall = 0, set_conflict = 0, evict_stall = 0, fsm_done = 0;
  logic [2:0] mshr_cnt = 3'd0;
  logic       do_rsp, do_fwd, do_flush, do_fence, do_cpu_req, busy, starve_boost;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: index of the granted stream (-1 none) and starvation count.
  int m_gnt = -1;
  int m_cnt = 0;

  l2_dispatch_arbiter #(
    .N_MSHR(4), .STARVE_LIMIT(8), .MSHR_CNT_W(3), .STARVE_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(rsp_valid), .fwd_valid_i(fwd_valid), .flush_valid_i(flush_valid),
    .fence_valid_i(fence_valid), .cpu_valid_i(cpu_valid),
    .fwd_stall_i(fwd_stall), .set_conflict_i(set_conflict), .evict_stall_i(evict_stall),
    .mshr_cnt_i(mshr_cnt), .fsm_done_i(fsm_done),
    .do_rsp_o(do_rsp), .do_fwd_o(do_fwd), .do_flush_o(do_flush), .do_fence_o(do_fence),
    .do_cpu_req_o(do_cpu_req), .busy_o(busy), .starve_boost_o(starve_boost)
  );

  always #5 clk = ~clk;

  function automatic bit cpu_ok();
    return cpu_valid && !set_conflict && !evict_stall && (int'(mshr_cnt) < N_MSHR);
  endfunction

  // Stream order: 0 rsp, 1 fwd, 2 flush, 3 fence, 4 cpu.
  function automatic int pick();
    if (rsp_valid) return 0;
    if (m_cnt == LIMIT && cpu_ok()) return 4;
    if (fwd_valid && !fwd_stall) return 1;
    if (flush_valid && mshr_cnt == 0) return 2;
    if (fence_valid && mshr_cnt == 0) return 3;
    if (cpu_ok()) return 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_gnt = -1;
      m_cnt = 0;
    end else begin
      if (m_gnt < 0 || fsm_done) begin
        w = pick();
        if (w == 4) m_cnt = 0;
        else if (w >= 0 && cpu_valid && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        m_gnt = w;
      end
      if (!cpu_valid) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_vec, act_vec;
    logic exp_busy, exp_boost;
    exp_vec   = (m_gnt >= 0) ? (5'd1 << m_gnt) : 5'd0;
    exp_busy  = (m_gnt >= 0);
    exp_boost = (m_cnt == LIMIT) && cpu_ok();
    act_vec   = {do_cpu_req, do_fence, do_flush, do_fwd, do_rsp};
    n_cmp++;
    if (act_vec !== exp_vec || busy !== exp_busy || starve_boost !== exp_boost) begin
      n_err++;
      $display("FAIL model t=%0t grant act=%b exp=%b busy act=%b exp=%b boost act=%b exp=%b",
               $time, act_vec, exp_vec, busy, exp_busy, starve_boost, exp_boost);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic done_pulse();
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
  endtask

  task automatic clear_inputs();
    rsp_valid = 0; fwd_valid = 0; flush_valid = 0; fence_valid = 0; cpu_valid = 0;
    fwd_stall = 0; set_conflict = 0; evict_stall = 0; fsm_done = 0; mshr_cnt = 3'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [4:0] gvec();
    return {do_cpu_req, do_fence, do_flush, do_fwd, do_rsp};
  endfunction

  initial begin
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_grant", 32'(gvec()), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Priority chain rsp -> fwd -> cpu.
    rsp_valid = 1; fwd_valid = 1; cpu_valid = 1;
    step();
    chk("prio_rsp", 32'(gvec()), 32'h01);
    rsp_valid = 0;
    step();
    done_pulse();
    chk("prio_fwd", 32'(gvec()), 32'h02);
    fwd_valid = 0;
    done_pulse();
    chk("prio_cpu", 32'(gvec()), 32'h10);
    cpu_valid = 0;
    done_pulse();
    chk("idle_after_done", 32'({busy, gvec()}), 32'h0);
    done_pulse();
    chk("spurious_done", 32'({busy, gvec()}), 32'h0);

    // Async reset mid-grant.
    fwd_valid = 1;
    step();
    chk("fwd_before_rst", 32'(gvec()), 32'h02);
    fwd_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'({busy, gvec()}), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 32'h0);

    // MSHR gating for CPU and flush; fwd_stall lets fence through.
    cpu_valid = 1; mshr_cnt = 3'd4;
    step();
    chk("cpu_mshr_full", 32'(gvec()), 32'h0);
    mshr_cnt = 3'd3;
    step();
    chk("cpu_mshr_free", 32'(gvec()), 32'h10);
    cpu_valid = 0;
    done_pulse();
    flush_valid = 1; mshr_cnt = 3'd1;
    step();
    chk("flush_blocked", 32'(gvec()), 32'h0);
    mshr_cnt = 3'd0;
    step();
    chk("flush_granted", 32'(gvec()), 32'h04);
    flush_valid = 0;
    done_pulse();
    fwd_valid = 1; fwd_stall = 1; fence_valid = 1;
    step();
    chk("fence_over_stalled_fwd", 32'(gvec()), 32'h08);
    do_reset();

    // Starvation: eight fwd grants, then the boosted CPU, then fwd again.
    cpu_valid = 1; fwd_valid = 1;
    step();
    for (int i = 1; i <= LIMIT; i++) begin
      chk($sformatf("starve_fwd_%0d", i), 32'(gvec()), 32'h02);
      if (i < LIMIT) begin
        step();
        done_pulse();
      end
    end
    chk("boost_on", 32'(starve_boost), 32'h1);
    step();
    done_pulse();
    chk("boost_cpu", 32'(gvec()), 32'h10);
    chk("boost_off", 32'(starve_boost), 32'h0);
    step();
    done_pulse();
    chk("fwd_after_boost", 32'(gvec()), 32'h02);

    // Boost vs response: build count back up to the limit, then raise rsp.
    for (int i = 2; i <= LIMIT; i++) done_pulse();
    chk("boost_again", 32'(starve_boost), 32'h1);
    rsp_valid = 1;
    done_pulse();
    chk("rsp_beats_boost", 32'(gvec()), 32'h01);
    rsp_valid = 0;
    done_pulse();
    chk("cpu_after_rsp", 32'(gvec()), 32'h10);
    do_reset();

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      rsp_valid    = ($urandom_range(0, 5) == 0);
      fwd_valid    = ($urandom_range(0, 1) == 0);
      flush_valid  = ($urandom_range(0, 3) == 0);
      fence_valid  = ($urandom_range(0, 3) == 0);
      cpu_valid    = ($urandom_range(0, 5) != 0);
      fwd_stall    = ($urandom_range(0, 3) == 0);
      set_conflict = ($urandom_range(0, 5) == 0);
      evict_stall  = ($urandom_range(0, 5) == 0);
      mshr_cnt     = 3'($urandom_range(0, 5));
      fsm_done     = ($urandom_range(0, 2) == 0);
      if (c == 2000) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      step();
    end
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
